// File: rtl/bullet_pkg.sv
// Shared types for the bullet scheduler slice: facing direction, owner id, fire keycodes.
package bullet_pkg;

  typedef enum logic [1:0] {
    DIR_L = 2'b00,
    DIR_R = 2'b01,
    DIR_D = 2'b10,
    DIR_U = 2'b11
  } dir_t;

  typedef enum logic {
    OWN_P1 = 1'b0,
    OWN_P2 = 1'b1
  } owner_t;

  localparam logic [7:0] KEY_SPACE = 8'd44;
  localparam logic [7:0] KEY_ENTER = 8'd40;

endpackage

// File: rtl/bullet_scheduler_if.sv
// Scheduler <-> keyboard/slot bundle; master is the scheduler, slave is the keyboard and slot side.
interface bullet_scheduler_if
  import bullet_pkg::*;
#(
  parameter int NUM_SLOTS = 4
);
  logic [7:0]           keycode0;
  logic [7:0]           keycode1;
  dir_t                 p1_dir;
  dir_t                 p2_dir;
  logic [NUM_SLOTS-1:0] slot_busy;
  logic [NUM_SLOTS-1:0] launch;
  dir_t                 launch_dir;
  owner_t               launch_owner;
  logic [NUM_SLOTS-1:0] slot_owner;
  logic [3:0]           p1_count;
  logic [3:0]           p2_count;
  logic                 p1_ready;
  logic                 p2_ready;

  modport master (
    input  keycode0, keycode1, p1_dir, p2_dir, slot_busy,
    output launch, launch_dir, launch_owner, slot_owner,
           p1_count, p2_count, p1_ready, p2_ready
  );

  modport slave (
    output keycode0, keycode1, p1_dir, p2_dir, slot_busy,
    input  launch, launch_dir, launch_owner, slot_owner,
           p1_count, p2_count, p1_ready, p2_ready
  );
endinterface

// File: rtl/bullet_scheduler_rr_pick2.sv
// Two-requester round-robin pick; the last-winner pointer only moves when both request.
module rr_pick2
  import bullet_pkg::*;
(
  input  logic   frame_clk,
  input  logic   Reset,
  input  logic   req_p1,
  input  logic   req_p2,
  output logic   grant_vld,
  output owner_t winner
);
  owner_t rr_last;

  always_comb begin
    grant_vld = req_p1 | req_p2;
    winner    = OWN_P1;
    if (req_p1 && req_p2)
      winner = (rr_last == OWN_P2) ? OWN_P1 : OWN_P2;
    else if (req_p2)
      winner = OWN_P2;
  end

  // Reset to P2 so P1 takes the very first tie.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset)
      rr_last <= OWN_P2;
    else if (req_p1 && req_p2)
      rr_last <= winner;
  end
endmodule

// File: rtl/bullet_scheduler.sv
// Per-frame bullet launcher: fire-key edge detect, cooldown and in-flight limits, round-robin
// between players, one launch pulse per frame into the lowest free slot.
module bullet_scheduler
  import bullet_pkg::*;
#(
  parameter int         NUM_SLOTS      = 4,
  parameter int         MAX_PER_PLAYER = 2,
  parameter int         COOLDOWN       = 6,
  parameter logic [7:0] P1_KEY         = KEY_SPACE,
  parameter logic [7:0] P2_KEY         = KEY_ENTER
)(
  input  logic                 frame_clk,
  input  logic                 Reset,
  bullet_scheduler_if.master   bus
);
  localparam int CD_W = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

  function automatic logic [3:0] popcount(input logic [NUM_SLOTS-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      c = c + {3'b000, v[i]};
    return c;
  endfunction

  function automatic logic [NUM_SLOTS-1:0] lowest_free(input logic [NUM_SLOTS-1:0] o);
    logic [NUM_SLOTS-1:0] oh;
    oh = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!o[i]) begin
        oh    = '0;
        oh[i] = 1'b1;
      end
    end
    return oh;
  endfunction

  logic [1:0]           key_prev;
  logic                 press_p1, press_p2, edge_p1, edge_p2;
  logic                 pend_p1, pend_p2;
  logic [CD_W-1:0]      cd_p1, cd_p2;
  logic [NUM_SLOTS-1:0] launch_r, launch_q, slot_owner_r, occ, free_oh;
  dir_t                 launch_dir_r;
  owner_t               launch_owner_r;
  logic [3:0]           p1_cnt, p2_cnt;
  logic                 pool_free, elig_p1, elig_p2;
  logic                 grant_vld;
  owner_t               winner;

  assign press_p1 = (bus.keycode0 == P1_KEY) | (bus.keycode1 == P1_KEY);
  assign press_p2 = (bus.keycode0 == P2_KEY) | (bus.keycode1 == P2_KEY);
  assign edge_p1  = press_p1 & ~key_prev[0];
  assign edge_p2  = press_p2 & ~key_prev[1];

  // A slot counts as taken while its pulse is out and for the frame after, until busy rises.
  assign occ       = bus.slot_busy | launch_r | launch_q;
  assign p1_cnt    = popcount(occ & ~slot_owner_r);
  assign p2_cnt    = popcount(occ & slot_owner_r);
  assign pool_free = ~&occ;
  assign free_oh   = lowest_free(occ);

  assign elig_p1 = pend_p1 & (cd_p1 == '0) & (p1_cnt < 4'(MAX_PER_PLAYER)) & pool_free;
  assign elig_p2 = pend_p2 & (cd_p2 == '0) & (p2_cnt < 4'(MAX_PER_PLAYER)) & pool_free;

  rr_pick2 u_rr (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .req_p1    (elig_p1),
    .req_p2    (elig_p2),
    .grant_vld (grant_vld),
    .winner    (winner)
  );

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      key_prev       <= '0;
      pend_p1        <= 1'b0;
      pend_p2        <= 1'b0;
      cd_p1          <= '0;
      cd_p2          <= '0;
      launch_r       <= '0;
      launch_q       <= '0;
      slot_owner_r   <= '0;
      launch_dir_r   <= DIR_L;
      launch_owner_r <= OWN_P1;
    end else begin
      key_prev <= {press_p2, press_p1};
      launch_q <= launch_r;
      launch_r <= '0;
      if (cd_p1 != '0) cd_p1 <= cd_p1 - CD_W'(1);
      if (cd_p2 != '0) cd_p2 <= cd_p2 - CD_W'(1);
      if (edge_p1) pend_p1 <= 1'b1;
      if (edge_p2) pend_p2 <= 1'b1;
      // Grant overrides a same-frame edge for the winner; cooldown would block it anyway.
      if (grant_vld) begin
        launch_r       <= free_oh;
        launch_owner_r <= winner;
        if (winner == OWN_P2) begin
          slot_owner_r <= slot_owner_r | free_oh;
          launch_dir_r <= bus.p2_dir;
          pend_p2      <= 1'b0;
          cd_p2        <= CD_W'(COOLDOWN);
        end else begin
          slot_owner_r <= slot_owner_r & ~free_oh;
          launch_dir_r <= bus.p1_dir;
          pend_p1      <= 1'b0;
          cd_p1        <= CD_W'(COOLDOWN);
        end
      end
    end
  end

  assign bus.launch       = launch_r;
  assign bus.launch_dir   = launch_dir_r;
  assign bus.launch_owner = launch_owner_r;
  assign bus.slot_owner   = slot_owner_r;
  assign bus.p1_count     = p1_cnt;
  assign bus.p2_count     = p2_cnt;
  assign bus.p1_ready     = elig_p1;
  assign bus.p2_ready     = elig_p2;
endmodule

// File: tb/tb_bullet_scheduler.sv
// Directed bench for bullet_scheduler with a simple slot model (busy rises the frame after launch).
module tb_bullet_scheduler;
  import bullet_pkg::*;

  logic       frame_clk = 1'b0;
  logic       Reset     = 1'b1;
  logic [3:0] busy;
  logic [3:0] set_mask  = 4'b0000;
  logic [3:0] kill_mask = 4'b0000;
  int         checks    = 0;
  int         failures  = 0;
  int         hits;
  int         gap;

  always #5 frame_clk = ~frame_clk;

  bullet_scheduler_if #(.NUM_SLOTS(4)) bus ();

  bullet_scheduler #(
    .NUM_SLOTS(4), .MAX_PER_PLAYER(2), .COOLDOWN(6), .P1_KEY(8'd44), .P2_KEY(8'd40)
  ) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  always @(posedge frame_clk or posedge Reset) begin
    if (Reset) busy <= 4'b0000;
    else       busy <= (busy | bus.launch | set_mask) & ~kill_mask;
  end
  assign bus.slot_busy = busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge frame_clk);
  endtask

  task automatic do_reset();
    Reset        = 1'b1;
    bus.keycode0 = 8'd0;
    bus.keycode1 = 8'd0;
    set_mask     = 4'b0000;
    kill_mask    = 4'b0000;
    tick(2);
    Reset = 1'b0;
  endtask

  task automatic watch(input int n, output int nhits);
    nhits = 0;
    repeat (n) begin
      tick();
      if (bus.launch != 4'b0000) nhits++;
    end
  endtask

  task automatic wait_launch(input int budget, output int g);
    g = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (bus.launch != 4'b0000) begin
        g = i;
        break;
      end
    end
  endtask

  initial begin
    bus.keycode0 = 8'd0;
    bus.keycode1 = 8'd0;
    bus.p1_dir   = DIR_L;
    bus.p2_dir   = DIR_L;
    tick(2);

    // Reset state
    check("rst_launch", 32'(bus.launch), 32'h0);
    check("rst_dir", 32'(bus.launch_dir), 32'h0);
    check("rst_owner", 32'(bus.launch_owner), 32'h0);
    check("rst_slot_owner", 32'(bus.slot_owner), 32'h0);
    check("rst_p1_count", 32'(bus.p1_count), 32'h0);
    check("rst_p1_ready", 32'(bus.p1_ready), 32'h0);
    Reset = 1'b0;

    // Single P1 shot, key held afterwards
    bus.keycode0 = 8'd44;
    bus.p1_dir   = DIR_R;
    tick();
    check("t1_ready", 32'(bus.p1_ready), 32'h1);
    tick();
    check("t1_launch", 32'(bus.launch), 32'h1);
    check("t1_dir", 32'(bus.launch_dir), 32'h1);
    check("t1_owner", 32'(bus.launch_owner), 32'h0);
    check("t1_p1_count", 32'(bus.p1_count), 32'h1);
    watch(20, hits);
    check("t1_hold_no_retrigger", 32'(hits), 32'h0);

    // Cooldown: re-press early, grant waits for cd to reach 0, pulse seen one frame later
    do_reset();
    bus.keycode0 = 8'd44;
    tick(2);
    check("t2_first_launch", 32'(bus.launch), 32'h1);
    bus.keycode0 = 8'd0;
    tick(2);
    bus.keycode0 = 8'd44;
    wait_launch(20, gap);
    check("t2_cooldown_gap", 32'(gap + 2), 32'd7);
    check("t2_second_slot", 32'(bus.launch), 32'h2);

    // Tie: P1 first, P2 next frame, next tie goes to P2
    do_reset();
    bus.p1_dir   = DIR_R;
    bus.p2_dir   = DIR_U;
    bus.keycode0 = 8'd44;
    bus.keycode1 = 8'd40;
    tick(2);
    check("t3_tie_launch", 32'(bus.launch), 32'h1);
    check("t3_tie_owner", 32'(bus.launch_owner), 32'h0);
    tick();
    check("t3_p2_launch", 32'(bus.launch), 32'h2);
    check("t3_p2_owner", 32'(bus.launch_owner), 32'h1);
    check("t3_p2_dir", 32'(bus.launch_dir), 32'h3);
    check("t3_p2_count", 32'(bus.p2_count), 32'h1);
    bus.keycode0 = 8'd0;
    bus.keycode1 = 8'd0;
    tick(10);
    bus.keycode0 = 8'd44;
    bus.keycode1 = 8'd40;
    tick(2);
    check("t3_tie2_launch", 32'(bus.launch), 32'h4);
    check("t3_tie2_owner", 32'(bus.launch_owner), 32'h1);
    tick();
    check("t3_tie2_p1_launch", 32'(bus.launch), 32'h8);
    check("t3_tie2_p1_owner", 32'(bus.launch_owner), 32'h0);
    check("t3_slot_owner", 32'(bus.slot_owner), 32'h6);

    // In-flight limit
    do_reset();
    bus.keycode1 = 8'd0;
    bus.keycode0 = 8'd44;
    tick(2);
    bus.keycode0 = 8'd0;
    tick(10);
    bus.keycode0 = 8'd44;
    tick(2);
    check("t4_second_launch", 32'(bus.launch), 32'h2);
    bus.keycode0 = 8'd0;
    tick(10);
    bus.keycode0 = 8'd44;
    tick();
    check("t4_p1_count", 32'(bus.p1_count), 32'h2);
    check("t4_ready_blocked", 32'(bus.p1_ready), 32'h0);
    watch(5, hits);
    check("t4_no_launch", 32'(hits), 32'h0);
    kill_mask = 4'b0001;
    tick();
    kill_mask = 4'b0000;
    check("t4_free_no_launch_yet", 32'(bus.launch), 32'h0);
    check("t4_ready_after_free", 32'(bus.p1_ready), 32'h1);
    tick();
    check("t4_refill_launch", 32'(bus.launch), 32'h1);

    // Pool full, P2 waits for slot 2
    do_reset();
    set_mask = 4'b1111;
    tick();
    set_mask     = 4'b0000;
    bus.p2_dir   = DIR_D;
    bus.keycode1 = 8'd40;
    tick();
    check("t5_ready_full", 32'(bus.p2_ready), 32'h0);
    watch(3, hits);
    check("t5_no_launch_full", 32'(hits), 32'h0);
    kill_mask = 4'b0100;
    tick();
    kill_mask = 4'b0000;
    check("t5_free_no_launch_yet", 32'(bus.launch), 32'h0);
    tick();
    check("t5_launch", 32'(bus.launch), 32'h4);
    check("t5_owner", 32'(bus.launch_owner), 32'h1);
    check("t5_dir", 32'(bus.launch_dir), 32'h2);
    check("t5_slot_owner", 32'(bus.slot_owner), 32'h4);

    // Reset with P2 pending and in cooldown
    do_reset();
    bus.p2_dir   = DIR_U;
    bus.keycode1 = 8'd40;
    tick(2);
    check("t6_pre_launch", 32'(bus.launch), 32'h1);
    bus.keycode1 = 8'd0;
    tick();
    bus.keycode1 = 8'd40;
    tick();
    check("t6_pre_ready_cd", 32'(bus.p2_ready), 32'h0);
    Reset = 1'b1;
    #1;
    check("t6_rst_launch", 32'(bus.launch), 32'h0);
    check("t6_rst_owner", 32'(bus.launch_owner), 32'h0);
    check("t6_rst_dir", 32'(bus.launch_dir), 32'h0);
    check("t6_rst_slot_owner", 32'(bus.slot_owner), 32'h0);
    check("t6_rst_p2_count", 32'(bus.p2_count), 32'h0);
    bus.keycode1 = 8'd0;
    tick();
    Reset = 1'b0;
    watch(8, hits);
    check("t6_no_launch_after_rst", 32'(hits), 32'h0);
    bus.keycode1 = 8'd40;
    tick(2);
    check("t6_launch_after_edge", 32'(bus.launch), 32'h1);
    check("t6_owner_after_edge", 32'(bus.launch_owner), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
